// File: rtl/ok_buffered_pipe_out.sv
// Buffered pipe-out endpoint model. Gateware pushes 16-bit words into a FIFO
// and the host drains them with the pipe-out read strobe. The FIFO head falls
// through onto ok2, so data is valid in the same cycle it is presented.
// A non-zero BLOCK_SIZE holds ready low until a whole block is queued. Once
// the first word of a block is popped, ready stays high until the block ends.
module ok_buffered_pipe_out #(
  parameter logic [7:0] EP_ADDR    = 8'hA0,
  parameter int         DEPTH      = 1024,
  parameter int         AW         = 10,
  parameter int         BLOCK_SIZE = 0
) (
  input  logic          ti_clk,
  input  logic          ti_reset,
  input  logic [7:0]    ti_addr,
  input  logic          ti_read,
  output logic [16:0]   ok2,
  output logic          ep_read,
  input  logic [15:0]   wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  // Parameter sanity; a bad configuration must not elaborate.
  generate
    if (EP_ADDR < 8'hA0 || EP_ADDR > 8'hBF) begin : g_bad_addr
      $error("ok_buffered_pipe_out: EP_ADDR out of range 8'hA0..8'hBF");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("ok_buffered_pipe_out: DEPTH must be a power of two >= 2");
    end
    if ((1 << AW) != DEPTH) begin : g_bad_aw
      $error("ok_buffered_pipe_out: AW must equal log2(DEPTH)");
    end
    if (BLOCK_SIZE < 0 || BLOCK_SIZE > DEPTH) begin : g_bad_block
      $error("ok_buffered_pipe_out: BLOCK_SIZE must be 0..DEPTH");
    end
  endgenerate

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] BS_C    = (AW+1)'(BLOCK_SIZE);
  localparam bit          BLK_EN  = (BLOCK_SIZE != 0);
  localparam bit          BLK_MUL = (BLOCK_SIZE > 1);

  typedef enum logic {IDLE, BURST} state_t;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic [AW:0]   blk_cnt, blk_nx, blk_inc;
  state_t        state, state_nx;
  logic          sel, rd_ok, wr_ok, ready;

  assign sel     = (ti_addr == EP_ADDR);
  assign empty   = (cnt == '0);
  assign full    = (cnt == DEPTH_C);
  assign count   = cnt;
  assign ep_read = ti_read && sel;
  assign rd_ok   = ep_read && !empty;
  // A pop in the same cycle frees the slot, so a write to a full FIFO lands.
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign ok2     = {ready, (sel && !empty) ? mem[rd_ptr] : 16'h0000};

  // Storage array; contents survive reset, only pointers are cleared.
  always_ff @(posedge ti_clk) begin
    if (!ti_reset && wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge ti_clk) begin
    if (ti_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (wr_en && full && !rd_ok) overflow  <= 1'b1;
      if (ep_read && empty)        underflow <= 1'b1;
    end
  end

  // Block-throttle state register.
  always_ff @(posedge ti_clk) begin
    if (ti_reset) begin
      state   <= IDLE;
      blk_cnt <= '0;
    end else begin
      state   <= state_nx;
      blk_cnt <= blk_nx;
    end
  end

  assign blk_inc = blk_cnt + 1'b1;

  // Ready generation and burst tracking; pipe mode just mirrors sel.
  always_comb begin
    state_nx = state;
    blk_nx   = blk_cnt;
    ready    = sel;
    if (BLK_EN) begin
      case (state)
        IDLE: begin
          ready = sel && (cnt >= BS_C);
          // Only a pop taken while a full block is queued opens a burst;
          // early host reads drain words without changing state.
          if (rd_ok && (cnt >= BS_C) && BLK_MUL) begin
            state_nx = BURST;
            blk_nx   = (AW+1)'(1);
          end
        end
        BURST: begin
          ready = sel;
          if (rd_ok) begin
            if (blk_inc == BS_C) begin
              state_nx = IDLE;
              blk_nx   = '0;
            end else begin
              blk_nx   = blk_inc;
            end
          end
        end
        default: begin
          state_nx = IDLE;
          blk_nx   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ok_buffered_pipe_out.sv
// Directed bench: a pipe-mode instance and a block-mode (BLOCK_SIZE=4)
// instance, both DEPTH=8, each with its own stimulus signals.
module tb_ok_buffered_pipe_out;

  logic ti_clk = 1'b0;
  always #5 ti_clk = ~ti_clk;

  int checks = 0;
  int errors = 0;

  // pipe-mode instance signals
  logic        p_rst, p_read, p_wr_en, p_ep_read, p_full, p_empty, p_ovf, p_unf;
  logic [7:0]  p_addr;
  logic [15:0] p_wr_data;
  logic [16:0] p_ok2;
  logic [3:0]  p_count;

  // block-mode instance signals
  logic        b_rst, b_read, b_wr_en, b_ep_read, b_full, b_empty, b_ovf, b_unf;
  logic [7:0]  b_addr;
  logic [15:0] b_wr_data;
  logic [16:0] b_ok2;
  logic [3:0]  b_count;

  ok_buffered_pipe_out #(.EP_ADDR(8'hA0), .DEPTH(8), .AW(3), .BLOCK_SIZE(0)) u_pipe (
    .ti_clk(ti_clk), .ti_reset(p_rst), .ti_addr(p_addr), .ti_read(p_read),
    .ok2(p_ok2), .ep_read(p_ep_read), .wr_data(p_wr_data), .wr_en(p_wr_en),
    .full(p_full), .empty(p_empty), .count(p_count),
    .overflow(p_ovf), .underflow(p_unf));

  ok_buffered_pipe_out #(.EP_ADDR(8'hA0), .DEPTH(8), .AW(3), .BLOCK_SIZE(4)) u_blk (
    .ti_clk(ti_clk), .ti_reset(b_rst), .ti_addr(b_addr), .ti_read(b_read),
    .ok2(b_ok2), .ep_read(b_ep_read), .wr_data(b_wr_data), .wr_en(b_wr_en),
    .full(b_full), .empty(b_empty), .count(b_count),
    .overflow(b_ovf), .underflow(b_unf));

  task automatic tick();
    @(posedge ti_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic p_write(input logic [15:0] d);
    p_wr_en = 1'b1; p_wr_data = d;
    tick();
    p_wr_en = 1'b0;
    #1;
  endtask

  task automatic b_write(input logic [15:0] d);
    b_wr_en = 1'b1; b_wr_data = d;
    tick();
    b_wr_en = 1'b0;
    #1;
  endtask

  // check the head word, then pop it
  task automatic p_pop(input string tag, input logic [15:0] d);
    p_read = 1'b1;
    #1;
    chk(tag, 32'(p_ok2[15:0]), 32'(d));
    tick();
    p_read = 1'b0;
    #1;
  endtask

  task automatic b_pop(input string tag, input logic [15:0] d, input logic rdy);
    b_read = 1'b1;
    #1;
    chk(tag, 32'(b_ok2[15:0]), 32'(d));
    chk({tag, "_rdy"}, 32'(b_ok2[16]), 32'(rdy));
    tick();
    b_read = 1'b0;
    #1;
  endtask

  logic [15:0] seq [3];

  initial begin
    p_rst = 1'b1; p_read = 1'b0; p_wr_en = 1'b0; p_addr = 8'h00; p_wr_data = '0;
    b_rst = 1'b1; b_read = 1'b0; b_wr_en = 1'b0; b_addr = 8'h00; b_wr_data = '0;
    seq[0] = 16'h1111; seq[1] = 16'h2222; seq[2] = 16'h3333;
    tick();
    tick();
    p_rst = 1'b0;

    // ---------------- pipe mode: reset / idle outputs ----------------
    p_addr = 8'hA0;
    #1;
    chk("rst_ok2_sel", 32'(p_ok2), 32'h10000);
    chk("rst_empty", 32'(p_empty), 32'd1);
    chk("rst_full", 32'(p_full), 32'd0);
    chk("rst_count", 32'(p_count), 32'd0);
    chk("rst_flags", 32'({p_ovf, p_unf}), 32'd0);
    p_addr = 8'h20;
    #1;
    chk("rst_ok2_unsel", 32'(p_ok2), 32'd0);
    p_addr = 8'hA0;

    // ---------------- ordering across pointer wrap ----------------
    for (int r = 0; r < 4; r++) begin
      p_write(seq[0]);
      if (r == 0) begin
        chk("fwft_data", 32'(p_ok2[15:0]), 32'h1111);
        chk("fwft_count", 32'(p_count), 32'd1);
        chk("fwft_empty", 32'(p_empty), 32'd0);
      end
      p_write(seq[1]);
      p_write(seq[2]);
      for (int k = 0; k < 3; k++) p_pop($sformatf("wrap_r%0d_w%0d", r, k), seq[k]);
      chk($sformatf("wrap_r%0d_empty", r), 32'(p_empty), 32'd1);
    end

    // ---------------- full / overflow / simultaneous ----------------
    for (int i = 0; i < 8; i++) p_write(16'h0A00 + 16'(i));
    chk("full_flag", 32'(p_full), 32'd1);
    chk("full_count", 32'(p_count), 32'd8);
    chk("full_no_ovf", 32'(p_ovf), 32'd0);
    p_write(16'hDEAD);
    chk("ovf_set", 32'(p_ovf), 32'd1);
    chk("ovf_count", 32'(p_count), 32'd8);
    p_wr_en = 1'b1; p_wr_data = 16'hBEEF; p_read = 1'b1;
    #1;
    chk("simul_head", 32'(p_ok2[15:0]), 32'h0A00);
    tick();
    p_wr_en = 1'b0; p_read = 1'b0;
    #1;
    chk("simul_count", 32'(p_count), 32'd8);
    chk("simul_full", 32'(p_full), 32'd1);
    for (int i = 1; i < 8; i++) p_pop($sformatf("drain_%0d", i), 16'h0A00 + 16'(i));
    p_pop("drain_beef", 16'hBEEF);
    chk("drain_empty", 32'(p_empty), 32'd1);

    // ---------------- underflow ----------------
    p_read = 1'b1;
    #1;
    chk("unf_ok2", 32'(p_ok2), 32'h10000);
    chk("unf_ep_read", 32'(p_ep_read), 32'd1);
    tick();
    p_read = 1'b0;
    #1;
    chk("unf_set", 32'(p_unf), 32'd1);
    chk("unf_count", 32'(p_count), 32'd0);
    p_wr_en = 1'b1; p_wr_data = 16'h5555; p_read = 1'b1;
    tick();
    p_wr_en = 1'b0; p_read = 1'b0;
    #1;
    chk("unf_wr_count", 32'(p_count), 32'd1);
    chk("unf_wr_data", 32'(p_ok2[15:0]), 32'h5555);
    chk("sticky_ovf", 32'(p_ovf), 32'd1);

    // ---------------- block mode ----------------
    b_rst = 1'b0;
    b_addr = 8'hA0;
    #1;
    chk("blk_rst_ok2", 32'(b_ok2), 32'd0);
    b_write(16'hC001);
    b_write(16'hC002);
    b_write(16'hC003);
    chk("blk_3_rdy", 32'(b_ok2[16]), 32'd0);
    chk("blk_3_count", 32'(b_count), 32'd3);
    b_write(16'hC004);
    chk("blk_4_rdy", 32'(b_ok2[16]), 32'd1);
    b_write(16'hC005);
    b_write(16'hC006);
    chk("blk_6_count", 32'(b_count), 32'd6);
    b_pop("burst_0", 16'hC001, 1'b1);
    b_pop("burst_1", 16'hC002, 1'b1);
    b_pop("burst_2", 16'hC003, 1'b1);
    // count is 3 here, below the block size: ready must hold within the burst
    b_pop("burst_3", 16'hC004, 1'b1);
    chk("post_burst_count", 32'(b_count), 32'd2);
    chk("post_burst_rdy", 32'(b_ok2[16]), 32'd0);
    chk("post_burst_head", 32'(b_ok2[15:0]), 32'hC005);

    // reads while not ready still pop, then underflow, state stays IDLE
    b_pop("nr_0", 16'hC005, 1'b0);
    chk("nr_0_rdy", 32'(b_ok2[16]), 32'd0);
    b_pop("nr_1", 16'hC006, 1'b0);
    b_pop("nr_unf", 16'h0000, 1'b0);
    chk("blk_unf", 32'(b_unf), 32'd1);
    chk("blk_unf_count", 32'(b_count), 32'd0);

    // fill past full for overflow, start a burst, then reset mid-burst
    for (int i = 0; i < 9; i++) b_write(16'hD000 + 16'(i));
    chk("blk_ovf", 32'(b_ovf), 32'd1);
    chk("blk_full_count", 32'(b_count), 32'd8);
    b_pop("rb_0", 16'hD000, 1'b1);
    b_pop("rb_1", 16'hD001, 1'b1);
    b_rst = 1'b1; b_wr_en = 1'b1; b_wr_data = 16'hEEEE; b_read = 1'b1;
    tick();
    b_rst = 1'b0; b_wr_en = 1'b0; b_read = 1'b0;
    #1;
    chk("mid_rst_count", 32'(b_count), 32'd0);
    chk("mid_rst_empty", 32'(b_empty), 32'd1);
    chk("mid_rst_ok2", 32'(b_ok2), 32'd0);
    chk("mid_rst_flags", 32'({b_ovf, b_unf}), 32'd0);
    // an FSM left in BURST would raise ready here
    b_write(16'hF001);
    b_write(16'hF002);
    b_write(16'hF003);
    chk("mid_rst_idle_rdy", 32'(b_ok2[16]), 32'd0);
    chk("mid_rst_head", 32'(b_ok2[15:0]), 32'hF001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
